disp_bcd_formatter: RTL and testbench



---
 rtl/disp_pkg.sv | 10 +
 rtl/bcd_add3.sv | 9 +
 rtl/disp_bcd_formatter.sv | 126 ++++++++++++
 tb/tb_disp_bcd_formatter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment display formatter.
package disp_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, FORMAT, DONE} state_e;

  localparam int unsigned BCD_DIGITS = 10;
  localparam int unsigned DEC_MAX    = 99_999_999;
  localparam logic [3:0]  OVF_CODE   = 4'hF;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] bcd,
  output logic [3:0] corrected
);

  assign corrected = (bcd >= 4'd5) ? bcd + 4'd3 : bcd;

endmodule

// File: rtl/disp_bcd_formatter.sv
// Formats a captured word into digit codes, blank mask and sign/overflow flags
// for the 8-digit scanner; decimal mode runs a bit-serial double-dabble.
module disp_bcd_formatter
  import disp_pkg::*;
#(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned WIDTH  = 32
) (
  input  logic                  clk_7seg,
  input  logic                  Rst,
  input  logic [WIDTH-1:0]      din,
  input  logic                  conv_en,
  input  logic                  dec_mode,
  input  logic                  signed_mode,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   digit_out,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  neg,
  output logic                  ovf,
  output logic                  valid,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned BcdW = 4 * BCD_DIGITS;
  localparam int unsigned DigW = 4 * DIGITS;

  state_e            state_q;
  logic [WIDTH-1:0]  mag_q;
  logic [BcdW-1:0]   bcd_q;
  logic [BcdW-1:0]   bcd_adj;
  logic [CntW-1:0]   cnt_q;
  logic              dec_q;
  logic              blz_q;
  logic              neg_q;

  logic [DigW-1:0]   fmt_result;
  logic [DIGITS-1:0] fmt_mask;
  logic              fmt_ovf;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .bcd       (bcd_q[4*g +: 4]),
      .corrected (bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    fmt_ovf    = 1'b0;
    fmt_result = DigW'(mag_q);
    if (dec_q) begin
      fmt_ovf    = |bcd_q[BcdW-1:DigW];
      fmt_result = fmt_ovf ? {DIGITS{OVF_CODE}} : bcd_q[DigW-1:0];
    end
    // Digit 0 always shows, so a zero value still displays "0".
    fmt_mask = '0;
    for (int i = 1; i < DIGITS; i++) begin
      fmt_mask[i] = blz_q & ~fmt_ovf & ((fmt_result >> (4 * i)) == '0);
    end
  end

  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      dec_q      <= 1'b0;
      blz_q      <= 1'b0;
      neg_q      <= 1'b0;
      digit_out  <= '0;
      blank_mask <= '0;
      neg        <= 1'b0;
      ovf        <= 1'b0;
      valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (conv_en) begin
            state_q <= LOAD;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          if (dec_mode & signed_mode & din[WIDTH-1]) begin
            mag_q <= ~din + WIDTH'(1);
            neg_q <= 1'b1;
          end else begin
            mag_q <= din;
            neg_q <= 1'b0;
          end
          dec_q   <= dec_mode;
          blz_q   <= blank_lz;
          bcd_q   <= '0;
          cnt_q   <= '0;
          state_q <= dec_mode ? SHIFT : FORMAT;
        end
        SHIFT: begin
          {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
          cnt_q          <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q <= FORMAT;
          end
        end
        FORMAT: begin
          digit_out  <= fmt_result;
          blank_mask <= fmt_mask;
          neg        <= neg_q;
          ovf        <= fmt_ovf;
          valid      <= 1'b1;
          busy       <= 1'b0;
          state_q    <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_bcd_formatter.sv
// Scoreboard bench: stimulus pushes expected results, a monitor checks each valid pulse.
module tb_disp_bcd_formatter;

  logic        clk_7seg = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] din = '0;
  logic        conv_en = 1'b0;
  logic        dec_mode = 1'b0;
  logic        signed_mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic [31:0] digit_out;
  logic [7:0]  blank_mask;
  logic        neg;
  logic        ovf;
  logic        valid;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int valid_cnt = 0;

  typedef struct {
    string       name;
    logic [31:0] dig;
    logic [7:0]  mask;
    logic        neg;
    logic        ovf;
    int          at;
  } exp_t;

  exp_t sb[$];

  disp_bcd_formatter #(
    .DIGITS (8),
    .WIDTH  (32)
  ) dut (
    .clk_7seg    (clk_7seg),
    .Rst         (Rst),
    .din         (din),
    .conv_en     (conv_en),
    .dec_mode    (dec_mode),
    .signed_mode (signed_mode),
    .blank_lz    (blank_lz),
    .digit_out   (digit_out),
    .blank_mask  (blank_mask),
    .neg         (neg),
    .ovf         (ovf),
    .valid       (valid),
    .busy        (busy)
  );

  always #5 clk_7seg = ~clk_7seg;

  always @(posedge clk_7seg) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  always @(negedge clk_7seg) begin : monitor
    exp_t e;
    if (!Rst && valid === 1'b1) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got digits %h required no valid", digit_out);
      end else begin
        e = sb.pop_front();
        chk({e.name, "/digits"}, digit_out, e.dig);
        chk({e.name, "/mask"}, {24'h0, blank_mask}, {24'h0, e.mask});
        chk({e.name, "/neg"}, {31'h0, neg}, {31'h0, e.neg});
        chk({e.name, "/ovf"}, {31'h0, ovf}, {31'h0, e.ovf});
        chk({e.name, "/latency"}, cyc, e.at);
      end
    end
  end

  task automatic push_exp(input string name, input logic [31:0] dig, input logic [7:0] mask,
                          input logic n, input logic o, input int at);
    exp_t e;
    e.name = name;
    e.dig  = dig;
    e.mask = mask;
    e.neg  = n;
    e.ovf  = o;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk_7seg);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s/timeout: got %0d pending results required 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk_7seg);
  endtask

  task automatic issue(input string name, input logic [31:0] d, input logic dm, input logic sm,
                       input logic bl, input logic [31:0] dig, input logic [7:0] mask,
                       input logic n, input logic o);
    @(negedge clk_7seg);
    din         = d;
    dec_mode    = dm;
    signed_mode = sm;
    blank_lz    = bl;
    conv_en     = 1'b1;
    push_exp(name, dig, mask, n, o, cyc + 1 + (dm ? 34 : 2));
    @(negedge clk_7seg);
    conv_en = 1'b0;
    drain(name);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n0;
    int vc;

    repeat (3) @(negedge clk_7seg);
    chk("rst/digits", digit_out, 32'h0);
    chk("rst/mask", {24'h0, blank_mask}, 32'h0);
    chk("rst/neg", {31'h0, neg}, 32'h0);
    chk("rst/ovf", {31'h0, ovf}, 32'h0);
    chk("rst/valid", {31'h0, valid}, 32'h0);
    chk("rst/busy", {31'h0, busy}, 32'h0);
    Rst = 1'b0;

    //    name          din           dec  sgn  blz  digits        mask   neg  ovf
    issue("hex_basic",  32'h1234ABCD, 1'b0, 1'b0, 1'b0, 32'h1234ABCD, 8'h00, 1'b0, 1'b0);
    issue("dec_basic",  32'h00BC614E, 1'b1, 1'b0, 1'b0, 32'h12345678, 8'h00, 1'b0, 1'b0);
    issue("dec_1e8",    32'h05F5E100, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 8'h00, 1'b0, 1'b1);
    issue("dec_max",    32'h05F5E0FF, 1'b1, 1'b0, 1'b0, 32'h99999999, 8'h00, 1'b0, 1'b0);
    issue("hex_lz_a00", 32'h00000A00, 1'b0, 1'b0, 1'b1, 32'h00000A00, 8'hF8, 1'b0, 1'b0);
    issue("hex_lz_0",   32'h00000000, 1'b0, 1'b0, 1'b1, 32'h00000000, 8'hFE, 1'b0, 1'b0);
    issue("dec_lz_0",   32'h00000000, 1'b1, 1'b0, 1'b1, 32'h00000000, 8'hFE, 1'b0, 1'b0);
    issue("dec_s_123",  32'h0000007B, 1'b1, 1'b1, 1'b1, 32'h00000123, 8'hF8, 1'b0, 1'b0);
    issue("dec_s_min",  32'h80000000, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 8'h00, 1'b1, 1'b1);
    issue("dec_u_ff",   32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 8'h00, 1'b0, 1'b1);
    issue("hex_sgn",    32'h80000000, 1'b0, 1'b1, 1'b0, 32'h80000000, 8'h00, 1'b0, 1'b0);

    // Back-to-back hex conversions with conv_en held high.
    @(negedge clk_7seg);
    din = 32'hCAFE0001; dec_mode = 1'b0; signed_mode = 1'b0; blank_lz = 1'b0; conv_en = 1'b1;
    n0 = cyc + 1;
    push_exp("b2b_first", 32'hCAFE0001, 8'h00, 1'b0, 1'b0, n0 + 2);
    push_exp("b2b_second", 32'h00BEEF00, 8'h00, 1'b0, 1'b0, n0 + 6);
    while (cyc < n0 + 1) @(negedge clk_7seg);
    din = 32'h00BEEF00;
    while (cyc < n0 + 4) @(negedge clk_7seg);
    conv_en = 1'b0;
    drain("b2b");

    // Inputs changed during SHIFT must not affect the running conversion.
    @(negedge clk_7seg);
    din = 32'h00BC614E; dec_mode = 1'b1; signed_mode = 1'b0; blank_lz = 1'b0; conv_en = 1'b1;
    n0 = cyc + 1;
    push_exp("mid_change", 32'h12345678, 8'h00, 1'b0, 1'b0, n0 + 34);
    @(negedge clk_7seg);
    conv_en = 1'b0;
    while (cyc < n0 + 6) @(negedge clk_7seg);
    din = 32'h00000000; dec_mode = 1'b0; blank_lz = 1'b1; signed_mode = 1'b1;
    drain("mid_change");

    issue("dec_s_m5",   32'hFFFFFFFB, 1'b1, 1'b1, 1'b1, 32'h00000005, 8'hFE, 1'b1, 1'b0);

    // Reset during SHIFT aborts the conversion and clears the outputs.
    @(negedge clk_7seg);
    din = 32'h00BC614E; dec_mode = 1'b1; signed_mode = 1'b0; blank_lz = 1'b0; conv_en = 1'b1;
    n0 = cyc + 1;
    @(negedge clk_7seg);
    conv_en = 1'b0;
    while (cyc < n0 + 11) @(negedge clk_7seg);
    chk("abort/busy_before", {31'h0, busy}, 32'h1);
    Rst = 1'b1;
    @(negedge clk_7seg);
    chk("abort/busy", {31'h0, busy}, 32'h0);
    chk("abort/digits", digit_out, 32'h0);
    chk("abort/mask", {24'h0, blank_mask}, 32'h0);
    chk("abort/neg", {31'h0, neg}, 32'h0);
    chk("abort/ovf", {31'h0, ovf}, 32'h0);
    chk("abort/valid", {31'h0, valid}, 32'h0);
    Rst = 1'b0;
    vc = valid_cnt;
    repeat (40) @(negedge clk_7seg);
    chk("abort/no_valid", valid_cnt, vc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
